// File: rtl/fifo_skew_reader.sv
// -----------------------------------------------------------------------------
// fifo_skew_reader
//
// Read-side sequencer for the per-lane FIFO array feeding the systolic array.
// It drains one tile of row_len words from each of array_size lanes.
// Lane i starts one step after lane i-1, which forms the diagonal wavefront
// that the PE rows expect. All lanes advance in lock-step. If any active lane
// is empty, every lane stalls for that cycle.
//
// Build option:
//   SKEW_READER_ZERO_PAD_EN
//     Defined   : dataOut lane i is driven to zero whenever valid[i] is low.
//     Undefined : dataOut lane i holds its last captured word.
//
// Ports:
//   r_clk    in  1                     clock, rising edge
//   clear    in  1                     synchronous active-high reset
//   start    in  1                     begin one tile (sampled in IDLE only)
//   empty    in  array_size            per-lane FIFO empty flags
//   dataIn   in  array_size*data_size  per-lane FIFO read data
//   r_en     out array_size            per-lane FIFO read enable (combinational)
//   dataOut  out array_size*data_size  registered skewed data to PE rows
//   valid    out array_size            registered per-lane data valid
//   busy     out 1                     high from first RUN cycle through DRAIN
//   done     out 1                     one-cycle pulse in DRAIN
// -----------------------------------------------------------------------------
module fifo_skew_reader #(
    parameter int data_size  = 8,
    parameter int array_size = 9,
    parameter int row_len    = 9,
    parameter int cnt_width  = 5
) (
    input  logic                             r_clk,
    input  logic                             clear,
    input  logic                             start,
    input  logic [array_size-1:0]            empty,
    input  logic [array_size*data_size-1:0]  dataIn,
    output logic [array_size-1:0]            r_en,
    output logic [array_size*data_size-1:0]  dataOut,
    output logic [array_size-1:0]            valid,
    output logic                             busy,
    output logic                             done
);

    // Number of wavefront steps in one tile.
    localparam int                   S         = row_len + array_size - 1;
    localparam logic [cnt_width-1:0] LAST_STEP = cnt_width'(S - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [cnt_width-1:0]            r_step;
    logic [cnt_width-1:0]            w_step_nxt;
    logic [array_size-1:0]           w_active;
    logic                            w_stall;
    logic [array_size-1:0]           r_valid;
    logic [array_size*data_size-1:0] r_data;

    // A lane is inside its read window while 0 <= step - lane < row_len.
    // The comparison is done in int so step - lane cannot wrap.
    function automatic logic lane_active(input logic [cnt_width-1:0] step,
                                         input int lane);
        int s;
        s = int'(step);
        return (s >= lane) && ((s - lane) < row_len);
    endfunction

    always_comb begin
        w_active = '0;
        for (int i = 0; i < array_size; i++) begin
            w_active[i] = lane_active(r_step, i);
        end
    end

    // Empty flags only matter on lanes inside their window.
    // A lane that has not started, or has finished, never stalls the array.
    assign w_stall = (r_state == RUN) && (|(w_active & empty));
    assign r_en    = ((r_state == RUN) && !w_stall) ? w_active : '0;

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DRAIN);
    assign valid   = r_valid;
    assign dataOut = r_data;

    // Next-state logic and step counter
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_step_nxt  = '0;
                end
            end
            RUN: begin
                // The step only moves on issuing cycles.
                // A stall on the last step therefore postpones DRAIN.
                if (!w_stall) begin
                    if (r_step == LAST_STEP) begin
                        w_state_nxt = DRAIN;
                        w_step_nxt  = '0;
                    end else begin
                        w_step_nxt = r_step + cnt_width'(1);
                    end
                end
            end
            DRAIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge r_clk) begin
        if (clear) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Output registers.
    // A word read in this cycle is captured at the closing edge. It is
    // presented together with its valid bit in the following cycle.
    always_ff @(posedge r_clk) begin
        if (clear) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= r_en;
            for (int i = 0; i < array_size; i++) begin
                if (r_en[i]) begin
                    r_data[i*data_size +: data_size] <= dataIn[i*data_size +: data_size];
                end else begin
`ifdef SKEW_READER_ZERO_PAD_EN
                    r_data[i*data_size +: data_size] <= '0;
`else
                    r_data[i*data_size +: data_size] <= r_data[i*data_size +: data_size];
`endif
                end
            end
        end
    end

endmodule
